// File: rtl/mov_pkg.sv
// Shared encodings for the move unit: command mode codes and FSM states.
// Imported by the move engine and by the control unit.
package mov_pkg;

  typedef enum logic [1:0] {
    MOV_ACC = 2'b00,
    MOV_IMM = 2'b01,
    MOV_BLK = 2'b10,
    MOV_ILL = 2'b11
  } mov_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } mov_state_e;

endpackage

// File: rtl/mov_addr_gen.sv
// Block-copy address generator: src/dst pointers that step up or down with
// wrap-around, plus the remaining-word counter for the copy loop.
module mov_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_ptr_o,
  output logic [ADDR_W-1:0] dst_ptr_o,
  output logic              cnt_zero_o
);

  localparam logic [ADDR_W-1:0] addr_one = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  len_one  = LEN_W'(1);

  logic              desc_q, desc_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] span;

  // Offset of the last word; a descending copy starts from the top of the block.
  assign span = ADDR_W'(len_i - len_one);

  // NOTE: every variable gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    desc_d = desc_q;
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      desc_d = dst_i > src_i;
      src_d  = desc_d ? src_i + span : src_i;
      dst_d  = desc_d ? dst_i + span : dst_i;
      cnt_d  = len_i;
    end else if (step_i) begin
      src_d = desc_q ? src_q - addr_one : src_q + addr_one;
      dst_d = desc_q ? dst_q - addr_one : dst_q + addr_one;
      cnt_d = cnt_q - len_one;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
    end else begin
      desc_q <= desc_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
    end
  end

  assign src_ptr_o  = src_q;
  assign dst_ptr_o  = dst_q;
  // High when the word being written now is the last one of the block.
  assign cnt_zero_o = (cnt_q == len_one);

endmodule

// File: rtl/mov_engine.sv
// Move unit: register moves of acc/imm and a memmove-safe block copy through
// a synchronous data-memory port, with abort and illegal-mode reporting.
module mov_engine
  import mov_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_acc,
  input  logic [DATA_W-1:0] data_imm,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mov_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              blk_load;
  logic              cnt_zero;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;

  assign blk_load = (state_q == ST_IDLE) && start &&
                    (mov_mode_e'(mode) == MOV_BLK) && (len != '0);

  mov_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (blk_load),
    .step_i    (state_q == ST_WRITE),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (len),
    .src_ptr_o (src_ptr),
    .dst_ptr_o (dst_ptr),
    .cnt_zero_o(cnt_zero)
  );

  // done/err/out_valid are registered so they line up with the edge that ends the command.
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (mov_mode_e'(mode))
            MOV_ACC: begin
              data_out_d  = data_acc;
              out_valid_d = 1'b1;
              done_d      = 1'b1;
            end
            MOV_IMM: begin
              data_out_d  = data_imm;
              out_valid_d = 1'b1;
              done_d      = 1'b1;
            end
            MOV_BLK: begin
              if (len == '0) done_d  = 1'b1;
              else           state_d = ST_READ;
            end
            MOV_ILL: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        data_out_d = mem_rd_data;
        if (abort || cnt_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = abort;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Memory strobes and buses are decoded from registered state only, so reset clears them at once.
  assign mem_rd_en   = (state_q == ST_READ);
  assign mem_wr_en   = (state_q == ST_WRITE);
  assign mem_rd_addr = mem_rd_en ? src_ptr : '0;
  assign mem_wr_addr = mem_wr_en ? dst_ptr : '0;
  assign mem_wr_data = mem_wr_en ? mem_rd_data : '0;
  assign busy        = mem_rd_en | mem_wr_en;
  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mov_engine.sv
// Self-checking bench for mov_engine: directed and random commands against a
// synchronous RAM model and a memmove-level reference of the expected result.
module tb_mov_engine;
  import mov_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] data_acc, data_imm;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data, data_out;
  logic          out_valid, busy, done, err;

  always #5 clk = ~clk;

  mov_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .data_acc(data_acc), .data_imm(data_imm), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .done(done), .err(err)
  );

  // Synchronous RAM model with a bench-side poke port and a random fill.
  logic [DW-1:0] mem [256];
  logic          fill, tb_we;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'($urandom);
    end else begin
      if (tb_we)     mem[tb_wa]       <= tb_wd;
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Issue one command; returns #1 after the accepting edge with start dropped.
  task automatic cmd(input logic [1:0] m, input logic [DW-1:0] acc, input logic [DW-1:0] imm,
                     input logic [LW-1:0] l);
    @(negedge clk);
    start = 1'b1; mode = m; data_acc = acc; data_imm = imm; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic reg_move(input string tag, input logic [1:0] m);
    logic [DW-1:0] acc, imm, exp;
    acc = DW'($urandom);
    imm = DW'($urandom);
    exp = (m == MOV_ACC) ? acc : imm;
    cmd(m, acc, imm, LW'(0));
    check({tag, " data_out"}, data_out, exp);
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " done"}, done, 1'b1);
    @(posedge clk); #1;
    check({tag, " pulse end"}, {out_valid, done, busy}, 3'b000);
  endtask

  // Block copy with expected read/write order, done cycle and final memory image.
  // abort_word >= 0 raises abort during the WRITE of that word.
  task automatic run_blk(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l, input int abort_word, input bit busy_start);
    logic [DW-1:0] old     [256];
    logic [DW-1:0] exp_mem [256];
    logic [AW-1:0] ra_q[$], wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] dout_before;
    int n_exp, done_j, nr, nw, mism, idx, n;
    bit seen_done;
    old = mem;
    exp_mem = old;
    n = int'(l);
    for (int i = 0; i < n; i++) begin
      idx = (d > s) ? n - 1 - i : i;
      ra_q.push_back(AW'(int'(s) + idx));
      wa_q.push_back(AW'(int'(d) + idx));
      wd_q.push_back(old[AW'(int'(s) + idx)]);
    end
    n_exp  = (abort_word >= 0) ? abort_word + 1 : n;
    done_j = (abort_word >= 0) ? 2 * abort_word + 3 : 2 * n + 1;
    if (abort_word < 0) begin
      for (int i = 0; i < n; i++) exp_mem[AW'(int'(d) + i)] = old[AW'(int'(s) + i)];
    end else begin
      for (int i = 0; i < n_exp; i++) exp_mem[wa_q[i]] = wd_q[i];
    end

    @(negedge clk);
    start = 1'b1; mode = MOV_BLK; src_addr = s; dst_addr = d; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    nr = 0; nw = 0; seen_done = 1'b0;
    for (int j = 1; j <= 2 * n + 6 && !seen_done; j++) begin
      if (j > 1) begin
        @(posedge clk); #1;
      end
      abort = 1'b0;
      start = 1'b0;
      if (mem_rd_en) begin
        if (nr < n_exp) check({tag, " rd_addr"}, mem_rd_addr, ra_q[nr]);
        else            check({tag, " read count"}, nr + 1, n_exp);
        nr++;
      end
      if (mem_wr_en) begin
        if (nw < n_exp) begin
          check({tag, " wr_addr"}, mem_wr_addr, wa_q[nw]);
          check({tag, " wr_data"}, mem_wr_data, wd_q[nw]);
        end else begin
          check({tag, " write count"}, nw + 1, n_exp);
        end
        nw++;
      end
      if (done) begin
        seen_done = 1'b1;
        check({tag, " done cycle"}, j, done_j);
        check({tag, " err"}, err, abort_word >= 0);
        check({tag, " busy at done"}, busy, 1'b0);
      end else begin
        check({tag, " busy"}, busy, 1'b1);
      end
      if (abort_word >= 0 && j == 2 * abort_word + 2) abort = 1'b1;
      if (busy_start && j == 2) begin
        start = 1'b1; mode = MOV_ACC; data_acc = 16'hDEAD;
        src_addr = s + 8'd7; len = l + 8'd3;
      end
    end
    check({tag, " done seen"}, seen_done, 1'b1);
    check({tag, " words written"}, nw, n_exp);
    if (n_exp > 0) check({tag, " data_out"}, data_out, wd_q[n_exp-1]);
    dout_before = data_out;
    if (busy_start) begin
      start = 1'b1; mode = MOV_ACC; data_acc = 16'h5A5A;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " after done"}, {done, err, busy, out_valid, mem_rd_en, mem_wr_en}, 6'b0);
    if (busy_start) check({tag, " start in DONE ignored"}, data_out, dout_before);
    mism = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) mism++;
    check({tag, " memory image"}, mism, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] prev;
    logic [AW-1:0] rs, rd;
    logic [LW-1:0] rl;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
    data_acc = '0; data_imm = '0; src_addr = '0; dst_addr = '0; len = '0;
    fill = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {mem_rd_en, mem_wr_en, out_valid, busy, done, err}, 6'b0);
    check("reset data_out", data_out, 16'h0);
    @(negedge clk);
    fill = 1'b0; rst = 1'b0;

    // Register moves, including the fixed immediate.
    cmd(MOV_IMM, 16'h1111, 16'hBEEF, LW'(0));
    check("imm data_out", data_out, 16'hBEEF);
    check("imm flags", {out_valid, done, busy, err}, 4'b1100);
    @(posedge clk); #1;
    check("imm pulse end", {out_valid, done}, 2'b00);
    check("imm held", data_out, 16'hBEEF);
    reg_move("acc", MOV_ACC);
    reg_move("imm rnd", MOV_IMM);

    // Ascending copy of known words.
    poke(8'd10, 16'd1);
    poke(8'd11, 16'd2);
    poke(8'd12, 16'd3);
    run_blk("asc", 8'd10, 8'd40, 8'd3, -1, 1'b0);
    check("asc mem40", mem[40], 16'd1);
    check("asc mem42", mem[42], 16'd3);

    run_blk("overlap", 8'd10, 8'd11, 8'd4, -1, 1'b0);
    run_blk("wrap", 8'hFE, 8'h20, 8'd4, -1, 1'b0);
    run_blk("wrap desc", 8'hF0, 8'hFD, 8'd6, -1, 1'b0);

    // Zero-length block: done next edge, no memory traffic.
    prev = data_out;
    cmd(MOV_BLK, 16'h0, 16'h0, LW'(0));
    check("len0 flags", {done, err, busy, mem_rd_en, mem_wr_en, out_valid}, 6'b100000);
    check("len0 data_out", data_out, prev);
    @(posedge clk); #1;
    check("len0 after", {done, busy, mem_rd_en, mem_wr_en}, 4'b0);

    // Illegal mode.
    cmd(MOV_ILL, 16'h7777, 16'h8888, LW'(0));
    check("ill flags", {done, err, out_valid, busy}, 4'b1100);
    check("ill data_out", data_out, prev);
    @(posedge clk); #1;
    check("ill after", {done, err}, 2'b00);

    run_blk("abort", 8'd100, 8'd150, 8'd5, 1, 1'b0);
    run_blk("busy start", 8'd50, 8'd70, 8'd3, -1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      rs = AW'($urandom);
      rd = AW'($urandom);
      rl = LW'($urandom_range(1, 16));
      run_blk($sformatf("rand%0d", k), rs, rd, rl, -1, 1'b0);
      reg_move($sformatf("rand mv%0d", k), ($urandom_range(0, 1) == 0) ? MOV_ACC : MOV_IMM);
    end

    // Reset during READ of a block.
    @(negedge clk);
    start = 1'b1; mode = MOV_BLK; src_addr = 8'd30; dst_addr = 8'd60; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst pre read", mem_rd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst strobes", {mem_rd_en, mem_wr_en, out_valid, busy, done, err}, 6'b0);
    check("rst data_out", data_out, 16'h0);
    check("rst addrs", {mem_rd_addr, mem_wr_addr}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    reg_move("post rst acc", MOV_ACC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
